// File: rtl/gpu_framebuffer.sv
// Double-buffered 16-bit framebuffer: GPU writes land in the back bank, scan-out reads the
// front bank, with a hardware back-bank clear and a vsync-synchronised bank swap.
module gpu_framebuffer #(
    parameter int unsigned FB_WIDTH    = 160,
    parameter int unsigned FB_HEIGHT   = 120,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [15:0] wr_color,
    input  logic        wr_write,
    input  logic        clear_req,
    input  logic        swap_req,
    input  logic        vsync,
    input  logic [7:0]  rd_x,
    input  logic [7:0]  rd_y,
    input  logic        rd_en,
    output logic [15:0] rd_color,
    output logic        rd_valid,
    output logic        busy,
    output logic        swap_pending,
    output logic        front_sel
);

    localparam int unsigned NPIX   = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              busy_nxt, swap_pending_nxt, front_sel_nxt;

    logic [15:0] bank0 [NPIX];
    logic [15:0] bank1 [NPIX];

    logic              wr_in_range_c, rd_in_range_c;
    logic [ADDR_W-1:0] wr_addr_c, rd_addr_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [15:0]       mem_data_c;
    logic [15:0]       rd_data_c;

    // Pixel address decode and clipping for both ports
    always_comb begin
        wr_in_range_c = (32'(wr_x) < FB_WIDTH) && (32'(wr_y) < FB_HEIGHT);
        rd_in_range_c = (32'(rd_x) < FB_WIDTH) && (32'(rd_y) < FB_HEIGHT);
        wr_addr_c     = ADDR_W'(32'(wr_y) * FB_WIDTH + 32'(wr_x));
        rd_addr_c     = ADDR_W'(32'(rd_y) * FB_WIDTH + 32'(rd_x));
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            busy         <= 1'b0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= clr_cnt_nxt;
            busy         <= busy_nxt;
            swap_pending <= swap_pending_nxt;
            front_sel    <= front_sel_nxt;
        end
    end

    // Next-state, back-bank write arbitration (GPU beats clear) and swap control
    always_comb begin
        state_nxt        = state;
        clr_cnt_nxt      = clr_cnt;
        busy_nxt         = busy;
        swap_pending_nxt = swap_pending;
        front_sel_nxt    = front_sel;
        mem_we_c         = 1'b0;
        mem_addr_c       = wr_addr_c;
        mem_data_c       = wr_color;

        if (wr_write && wr_in_range_c) begin
            mem_we_c = 1'b1;
        end else if (state == CLEAR && !wr_write) begin
            mem_we_c   = 1'b1;
            mem_addr_c = clr_cnt;
            mem_data_c = CLEAR_COLOR;
        end

        if (state == IDLE) begin
            if (clear_req) begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
                busy_nxt    = 1'b1;
            end
        end else if (!wr_write) begin
            if (clr_cnt == ADDR_W'(NPIX - 1)) begin
                state_nxt   = IDLE;
                clr_cnt_nxt = '0;
                busy_nxt    = 1'b0;
            end else begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
        end

        if (vsync && swap_pending && state == IDLE) begin
            front_sel_nxt    = ~front_sel;
            swap_pending_nxt = 1'b0;
        end else if (swap_req) begin
            swap_pending_nxt = 1'b1;
        end
    end

    // Back bank is the one not selected as front
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            if (front_sel) bank0[mem_addr_c] <= mem_data_c;
            else           bank1[mem_addr_c] <= mem_data_c;
        end
    end

    always_comb begin
        rd_data_c = '0;
        if (rd_in_range_c) rd_data_c = front_sel ? bank1[rd_addr_c] : bank0[rd_addr_c];
    end

    // Scan-out read port, one cycle latency, color held between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_color <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_color <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_gpu_framebuffer.sv
// Self-checking bench for gpu_framebuffer: directed scenarios plus randomized traffic,
// compared every cycle against a pixel-array reference model.
module tb_gpu_framebuffer;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk, rstn;
    logic [7:0]  wr_x, wr_y, rd_x, rd_y;
    logic [15:0] wr_color;
    logic        wr_write, clear_req, swap_req, vsync, rd_en;
    logic [15:0] rd_color;
    logic        rd_valid, busy, swap_pending, front_sel;

    int checks = 0;
    int errors = 0;

    gpu_framebuffer dut (
        .clk(clk), .rstn(rstn),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_write(wr_write),
        .clear_req(clear_req), .swap_req(swap_req), .vsync(vsync),
        .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en),
        .rd_color(rd_color), .rd_valid(rd_valid), .busy(busy),
        .swap_pending(swap_pending), .front_sel(front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: two pixel arrays, a clear progress index and swap bookkeeping
    logic [15:0] m_mem [2][NPIX];
    bit          m_kn  [2][NPIX];
    bit          m_front = 1'b0, m_pend = 1'b0, m_clr = 1'b0, m_valid = 1'b0, m_known = 1'b1;
    int          m_ptr = 0;
    logic [15:0] m_color = 16'h0;

    function automatic bit in_range(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) < W) && (int'(y) < H);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_front <= 1'b0; m_pend <= 1'b0; m_clr <= 1'b0; m_ptr <= 0;
            m_valid <= 1'b0; m_color <= 16'h0; m_known <= 1'b1;
        end else begin
            m_valid <= rd_en;
            if (rd_en) begin
                if (in_range(rd_x, rd_y)) begin
                    m_color <= m_mem[int'(m_front)][int'(rd_y) * W + int'(rd_x)];
                    m_known <= m_kn[int'(m_front)][int'(rd_y) * W + int'(rd_x)];
                end else begin
                    m_color <= 16'h0;
                    m_known <= 1'b1;
                end
            end
            if (wr_write && in_range(wr_x, wr_y)) begin
                m_mem[int'(!m_front)][int'(wr_y) * W + int'(wr_x)] <= wr_color;
                m_kn[int'(!m_front)][int'(wr_y) * W + int'(wr_x)]  <= 1'b1;
            end
            if (m_clr) begin
                if (!wr_write) begin
                    m_mem[int'(!m_front)][m_ptr] <= 16'h0000;
                    m_kn[int'(!m_front)][m_ptr]  <= 1'b1;
                    m_ptr <= m_ptr + 1;
                    if (m_ptr == NPIX - 1) m_clr <= 1'b0;
                end
            end else if (clear_req) begin
                m_clr <= 1'b1;
                m_ptr <= 0;
            end
            if (vsync && m_pend && !m_clr) begin
                m_front <= !m_front;
                m_pend  <= 1'b0;
            end else if (swap_req) begin
                m_pend <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("swap_pending", 32'(swap_pending), 32'(m_pend));
        check("busy", 32'(busy), 32'(m_clr));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_known) check("rd_color", 32'(rd_color), 32'(m_color));
    end

    task automatic nxt();
        @(negedge clk);
        wr_write = 1'b0; clear_req = 1'b0; swap_req = 1'b0; vsync = 1'b0; rd_en = 1'b0;
    endtask

    task automatic gpu_write(input int x, input int y, input logic [15:0] c);
        wr_x = 8'(x); wr_y = 8'(y); wr_color = c; wr_write = 1'b1;
    endtask

    task automatic read_px(input int x, input int y);
        rd_x = 8'(x); rd_y = 8'(y); rd_en = 1'b1;
    endtask

    function automatic logic [7:0] rnd_coord(input int edge_lo);
        if ($urandom_range(0, 3) == 0) return 8'(edge_lo + int'($urandom_range(0, 19)));
        return 8'($urandom_range(0, 7));
    endfunction

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            wr_x = rnd_coord(150); wr_y = rnd_coord(110);
            wr_color = 16'($urandom());
            wr_write = ($urandom_range(0, 1) == 1);
            rd_x = rnd_coord(150); rd_y = rnd_coord(110);
            rd_en = ($urandom_range(0, 1) == 1);
            swap_req = ($urandom_range(0, 5) == 0);
            vsync = ($urandom_range(0, 7) == 0);
            nxt();
        end
    endtask

    int n;

    initial begin
        rstn = 1'b0;
        wr_x = '0; wr_y = '0; wr_color = '0; rd_x = '0; rd_y = '0;
        wr_write = 1'b0; clear_req = 1'b0; swap_req = 1'b0; vsync = 1'b0; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_front_sel", 32'(front_sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_color", 32'(rd_color), 32'd0);
        rstn = 1'b1;
        nxt();

        // Write, swap, read back
        gpu_write(3, 2, 16'hBEEF); nxt();
        swap_req = 1'b1; nxt();
        check("swap_latched", 32'(swap_pending), 32'd1);
        vsync = 1'b1; nxt();
        check("swap_front1", 32'(front_sel), 32'd1);
        read_px(3, 2); nxt();
        check("rd_valid_beef", 32'(rd_valid), 32'd1);
        check("rd_color_beef", 32'(rd_color), 32'hBEEF);
        nxt();
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("rd_color_hold", 32'(rd_color), 32'hBEEF);

        // Clipping: out-of-range writes must not alias onto neighbours
        gpu_write(0, 5, 16'h0F0F); nxt();
        gpu_write(0, 6, 16'h0A0A); nxt();
        gpu_write(160, 5, 16'h1234); nxt();
        gpu_write(0, 120, 16'h5678); nxt();
        swap_req = 1'b1; nxt();
        vsync = 1'b1; nxt();
        check("swap_front0", 32'(front_sel), 32'd0);
        read_px(0, 5); nxt();
        check("clip_0_5", 32'(rd_color), 32'h0F0F);
        read_px(0, 6); nxt();
        check("clip_0_6", 32'(rd_color), 32'h0A0A);
        read_px(200, 0); nxt();
        check("oob_read", 32'(rd_color), 32'h0000);
        check("oob_valid", 32'(rd_valid), 32'd1);

        // Clear with a GPU collision on clear cycle 10, plus swap gating during the clear
        clear_req = 1'b1; nxt();
        n = 0;
        do begin
            n++;
            if (n == 10) gpu_write(0, 0, 16'hAAAA);
            if (n == 100) swap_req = 1'b1;
            if (n == 200) begin vsync = 1'b1; clear_req = 1'b1; end
            if (n == 300) begin
                check("gate_pending", 32'(swap_pending), 32'd1);
                check("gate_front", 32'(front_sel), 32'd0);
            end
            nxt();
        end while (busy && n < 20005);
        check("busy_cycles", 32'(n), 32'd19201);
        check("pending_after_clear", 32'(swap_pending), 32'd1);
        vsync = 1'b1; nxt();
        check("gate_swap_front", 32'(front_sel), 32'd1);
        check("gate_swap_pending", 32'(swap_pending), 32'd0);
        read_px(0, 0); nxt();
        check("clear_collision", 32'(rd_color), 32'hAAAA);
        read_px(159, 119); nxt();
        check("clear_last", 32'(rd_color), 32'h0000);

        // Read on the swapping edge sees the old front bank
        swap_req = 1'b1; nxt();
        vsync = 1'b1; read_px(0, 5); nxt();
        check("coinc_front", 32'(front_sel), 32'd0);
        check("coinc_old_bank", 32'(rd_color), 32'h0000);
        read_px(0, 5); nxt();
        check("coinc_new_bank", 32'(rd_color), 32'h0F0F);

        random_cycles(4000);

        // Asynchronous reset in the middle of a clear
        clear_req = 1'b1; nxt();
        random_cycles(60);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_front_sel", 32'(front_sel), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_pending", 32'(swap_pending), 32'd0);
        check("async_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rd_color", 32'(rd_color), 32'd0);
        nxt(); nxt();
        rstn = 1'b1;
        random_cycles(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
